// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with a hold limit.
// The priority start point rotates past each owner on release.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] gnt_id,
    output logic       valid,
    output logic       timeout
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t        r_state;
    logic [2:0]    r_ptr;
    logic [HW-1:0] r_hcnt;
    logic [2:0]    r_owner;
    logic [7:0]    r_grant;
    logic          r_valid;
    logic          r_timeout;

    logic [2:0]    w_pick;
    logic          w_any;
    logic          w_limit;
    logic          w_drop;
    logic          w_release;

    // First set request searching upward from the pointer, wrapping 7 to 0
    always_comb begin
        logic [2:0] idx;
        w_pick = 3'd0;
        w_any  = 1'b0;
        idx    = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = r_ptr + 3'(k);
            if (req[idx]) begin
                w_pick = idx;
                w_any  = 1'b1;
            end
        end
    end

    // Release causes for the current owner
    always_comb begin
        w_limit   = (r_hcnt == HW'(MAX_HOLD - 1));
        w_drop    = ~req[r_owner];
        w_release = done | w_drop | ~enable | w_limit;
    end

    // Arbiter FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 3'd0;
            r_hcnt    <= '0;
            r_owner   <= 3'd0;
            r_grant   <= 8'h00;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (enable && w_any) begin
                        r_owner <= w_pick;
                        r_grant <= 8'h01 << w_pick;
                        r_valid <= 1'b1;
                        r_hcnt  <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state   <= S_IDLE;
                        r_grant   <= 8'h00;
                        r_valid   <= 1'b0;
                        r_ptr     <= r_owner + 3'd1;
                        r_timeout <= w_limit & ~done & ~w_drop & enable;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant   = r_grant;
    assign gnt_id  = r_owner;
    assign valid   = r_valid;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed and random checks of rr_arbiter8
// against a behavioural round-robin model.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 16;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] gnt_id;
    logic       valid;
    logic       timeout;

    int errs   = 0;
    int checks = 0;

    // behavioural model state
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .req(req),
        .done(done),
        .grant(grant),
        .gnt_id(gnt_id),
        .valid(valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input int p, input logic [7:0] r);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    // Model reaction to one rising edge, using the inputs seen at that edge
    task automatic model_edge();
        bit rel;
        bit lim;
        if (rst) begin
            m_busy  = 0;
            m_owner = 0;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 0;
        end else begin
            m_to = 0;
            if (!m_busy) begin
                if (enable && req != 8'h00) begin
                    m_owner = first_from(m_ptr, req);
                    m_busy  = 1;
                    m_held  = 1;
                end
            end else begin
                lim = (m_held == MAX_HOLD);
                rel = done || !req[m_owner] || !enable || lim;
                if (rel) begin
                    m_busy = 0;
                    m_ptr  = (m_owner + 1) % 8;
                    m_to   = lim && !done && req[m_owner] && enable;
                end else begin
                    m_held++;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("grant", grant, m_busy ? (32'd1 << m_owner) : 32'd0);
        chk("valid", valid, m_busy);
        chk("timeout", timeout, m_to);
        if (m_busy) chk("gnt_id", gnt_id, m_owner);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int cnt;
        rst    = 1'b1;
        enable = 1'b0;
        req    = 8'h00;
        done   = 1'b0;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
        #1;
        tick();
        tick();
        chk("rst_grant", grant, 8'h00);
        chk("rst_gnt_id", gnt_id, 3'd0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_timeout", timeout, 1'b0);

        // wrap via pointer: 0, then 7, then 0 again
        rst = 1'b0; enable = 1'b1; req = 8'h81;
        tick();
        chk("wrap_first", grant, 8'h01);
        chk("wrap_first_id", gnt_id, 3'd0);
        done = 1'b1; tick(); done = 1'b0;
        chk("wrap_dead", valid, 1'b0);
        tick();
        chk("wrap_second", grant, 8'h80);
        chk("wrap_second_id", gnt_id, 3'd7);
        done = 1'b1; tick(); done = 1'b0;
        tick();
        chk("wrap_third", grant, 8'h01);

        // full rotation with done on each grant's second cycle
        rst = 1'b1; tick(); rst = 1'b0;
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick();
            chk("rot_id", gnt_id, g % 8);
            chk("rot_valid", valid, 1'b1);
            tick();
            done = 1'b1; tick(); done = 1'b0;
            chk("rot_gap", valid, 1'b0);
        end

        // hold limit with a lone request
        rst = 1'b1; tick(); rst = 1'b0;
        req = 8'h04;
        tick();
        cnt = 0;
        while (valid && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("hold_cycles", cnt, MAX_HOLD);
        chk("hold_timeout", timeout, 1'b1);
        req = 8'hFF;
        tick();
        chk("hold_ptr3", gnt_id, 3'd3);
        chk("hold_pulse", timeout, 1'b0);

        // owner 5 drops its request while 2 is waiting
        done = 1'b1; tick(); done = 1'b0;
        req = 8'h24;
        tick();
        chk("drop_own5", gnt_id, 3'd5);
        tick();
        req = 8'h04;
        tick();
        chk("drop_rel", grant, 8'h00);
        tick();
        chk("drop_wrap", grant, 8'h04);

        // enable low during a grant of index 3
        req = 8'h08;
        done = 1'b1; tick(); done = 1'b0;
        tick();
        chk("en_own3", grant, 8'h08);
        enable = 1'b0;
        tick();
        chk("en_rel", valid, 1'b0);
        chk("en_no_to", timeout, 1'b0);
        req = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("en_block", valid, 1'b0);
        end
        enable = 1'b1;

        // reset in the middle of a long grant
        tick();
        for (int i = 0; i < 10; i++) tick();
        chk("mid_valid", valid, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst_grant", grant, 8'h00);
        chk("mid_rst_valid", valid, 1'b0);
        rst = 1'b0;
        tick();
        chk("mid_rst_first", gnt_id, 3'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            req    = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = req | 8'($urandom);
            done   = ($urandom_range(0, 9) == 0);
            enable = ($urandom_range(0, 15) != 0);
            rst    = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 4) == 0) req = 8'hFF;
            tick();
        end
        rst = 1'b0; done = 1'b0; enable = 1'b1;
        // long holds to reach the limit under random masks
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) req = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one downstream resource between 8 requesters. It uses the same bit-to-index priority encoding as the existing 8:3 encoder, but rotates the priority start point after every grant so that no requester starves. It holds each grant until the owner signals completion, drops its request, or exceeds a hold limit. It sits between the requester array and the shared datapath, and drives that datapath's select lines (`gnt_id`) and a qualifying `valid`.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum cycles one grant may be held. Legal range 2..256.

Ports:
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: arbitration enable. Low blocks new grants and forces release of any current grant.
- `req`  in  8: request vector, one bit per requester; bit 0 is index 0.
- `done`  in  1: the current owner has finished. Sampled only in GRANT.
- `grant`  out  8: one-hot grant; all zeros when nothing is granted.
- `gnt_id`  out  3: binary index of the owner. Meaningful only while `valid`=1.
- `valid`  out  1: a grant is active.
- `timeout`  out  1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- State: FSM {IDLE, GRANT}; 3-bit rotating pointer `ptr`; hold counter `hcnt` of width clog2(MAX_HOLD); registered owner index.
- Reset (`rst`=1 at an edge):
  - state=IDLE, `ptr`=0, `hcnt`=0.
  - `grant`=8'h00, `gnt_id`=3'b000, `valid`=0, `timeout`=0.
  - Reset overrides everything, including mid-grant.
- IDLE:
  - If `enable`=1 and `req`≠0, select the first set `req` bit searching upward from index `ptr`, wrapping 7→0.
  - Register that index into the owner, set `grant` one-hot and `valid`=1, clear `hcnt`, go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- GRANT, evaluated each edge; release when any of these holds:
  - (a) `done`=1;
  - (b) `req[owner]`=0;
  - (c) `enable`=0;
  - (d) `hcnt`=MAX_HOLD-1.
- On release:
  - state→IDLE; `grant`=0, `valid`=0.
  - `ptr`=(owner+1) mod 8, wrapping from 7 to 0.
  - `timeout`=1 for one cycle only if (d) is the sole release cause. If `done` or a request drop coincides with the limit, there is no timeout.
- Without release: `hcnt` increments, and `grant`/`gnt_id` are held stable.
- `req` changes on non-owner bits during GRANT have no effect until the next IDLE.
- `grant` is always one-hot or zero. `gnt_id` equals the encoded `grant` whenever `valid`=1.

## Timing
- Grant latency: a request sampled at edge t in IDLE gives `grant`/`valid` high after edge t, i.e. visible during cycle t+1.
- Release: a cause sampled at edge t drops `grant` after edge t.
- Dead cycle: at least one cycle with `valid`=0 always separates consecutive grants. The next grant is visible no earlier than two cycles after the release-cause edge.
- Hold limit: a grant lasts at most MAX_HOLD cycles with `valid`=1.
- `timeout` is asserted in the same cycle that `valid` first reads 0.
- Simultaneous events:
  - `done` together with the limit → a normal release.
  - `rst` together with any event → reset wins.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then `req`=8'h81 with `enable`=1: expect `grant`=8'h01 and `gnt_id`=0. Pulse `done`; after the dead cycle expect `grant`=8'h80 and `gnt_id`=7. After the next `done`, expect `grant`=8'h01 again (wrap via `ptr`=0).
- `req`=8'hFF held and `done` pulsed on every grant's second cycle: grants must cycle through 0,1,…,7,0 in order, each separated by exactly one `valid`=0 cycle.
- MAX_HOLD=16, `req`=8'h04 held, `done`=0: `valid` stays high exactly 16 cycles. `timeout` pulses for one cycle as `valid` falls, and `ptr`=3 afterwards.
- Owner 5 drops `req[5]` mid-grant while `req[2]` is high: `grant` goes to 0 on the next edge. Then `grant`=8'h04, because the search starts at `ptr`=6 and wraps.
- `enable`=0 during a grant of index 3: release on the next edge with no timeout. No new grant appears while `enable`=0, even with `req`=8'hFF.
- `rst` asserted during a grant with `hcnt`=10: all outputs are 0 on the next cycle. After release of `rst` with `req`=8'hFF, the first grant is index 0.
